// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decoder.
// Accepts one instruction per cycle from fetch, optionally fetches an operand
// from the data port, and holds the decoded class flags, source/condition
// flags and a WIDTH-bit right-hand operand for execute until it is consumed.
module decode_stage #(
   parameter int WIDTH      = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      inst,
   output logic                  data_req,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      rhs,
   output logic                  op_nop,
   output logic                  op_out_lo,
   output logic                  op_load,
   output logic                  op_add,
   output logic                  op_store,
   output logic                  op_branch,
   output logic                  op_if,
   output logic                  op_illegal,
   output logic                  src_imm,
   output logic                  src_ram,
   output logic                  if_zero,
   output logic                  if_not_zero,
   output logic                  if_else,
   output logic                  if_not_else
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Decoded fields held for execute. cls is one-hot, bit 7 = nop down to
   // bit 0 = illegal; ifs is {zero, not_zero, else, not_else}. hi remembers
   // whether a fetched operand lands in the upper byte.
   typedef struct packed {
      logic [7:0]       cls;
      logic             src_imm;
      logic             src_ram;
      logic [3:0]       ifs;
      logic             hi;
      logic [WIDTH-1:0] rhs;
   } dec_t;

   state_t     state_q, state_d;
   dec_t       dec_q, dec_d;
   dec_t       new_dec;
   logic       new_fetch;
   logic       accept;
   logic       inst_unused;

   // Only the low 16 bits of the instruction carry meaning.
   assign inst_unused = ^inst;

   // Decode one 16-bit instruction word; a data-port operand is filled in later.
   function automatic dec_t decode(input logic [15:0] i);
      dec_t r;
      r = '0;
      if (i[15:8] == 8'h00) begin
         r.cls[7] = 1'b1;
      end else if (i[15:8] == 8'h08) begin
         r.cls[6] = 1'b1;
      end else if (i[15:11] inside {5'b10000, 5'b10001, 5'b10010}) begin
         case (i[15:11])
            5'b10000: r.cls[5] = 1'b1;
            5'b10001: r.cls[4] = 1'b1;
            default:  r.cls[3] = 1'b1;
         endcase
         if (i[10]) begin
            r.src_ram = 1'b1;
            r.rhs     = WIDTH'(i[7:0]);
         end else begin
            r.src_imm = 1'b1;
            r.hi      = i[8];
            if (!i[9]) begin
               r.rhs = i[8] ? (WIDTH'(i[7:0]) << 8) : WIDTH'(i[7:0]);
            end
         end
      end else if (i[15:11] == 5'b11000) begin
         r.cls[2] = 1'b1;
         r.rhs    = {{(WIDTH-11){i[10]}}, i[10:0]};
      end else if (i[15:11] == 5'b11110 && i[10:5] == 6'd0 && i[3:1] == 3'd0) begin
         // Legal conditions are 0x000/0x001/0x010/0x011: bit 4 picks the
         // zero/else family, bit 0 picks the negated form.
         r.cls[1] = 1'b1;
         r.ifs    = {~i[4] & ~i[0], ~i[4] & i[0], i[4] & ~i[0], i[4] & i[0]};
      end else begin
         r.cls[0] = 1'b1;
      end
      return r;
   endfunction

   // Load/add/store with source mode 010 or 011 take their operand from data.
   function automatic logic needs_fetch(input logic [15:0] i);
      return (i[15:11] inside {5'b10000, 5'b10001, 5'b10010}) && (i[10:9] == 2'b01);
   endfunction

   // Position a fetched operand in the low or high byte lane of rhs.
   function automatic logic [WIDTH-1:0] place_data(input logic [DATA_WIDTH-1:0] d,
                                                   input logic hi);
      logic [WIDTH-1:0] z;
      z = WIDTH'(d);
      return hi ? (z << 8) : z;
   endfunction

   assign new_dec   = decode(inst[15:0]);
   assign new_fetch = needs_fetch(inst[15:0]);

   assign in_ready  = !rst && !flush &&
                      ((state_q == IDLE) || ((state_q == FULL) && out_ready));
   assign accept    = in_valid && in_ready;

   assign out_valid = (state_q == FULL);
   assign data_req  = (state_q == FETCH);

   assign rhs         = dec_q.rhs;
   assign op_nop      = dec_q.cls[7];
   assign op_out_lo   = dec_q.cls[6];
   assign op_load     = dec_q.cls[5];
   assign op_add      = dec_q.cls[4];
   assign op_store    = dec_q.cls[3];
   assign op_branch   = dec_q.cls[2];
   assign op_if       = dec_q.cls[1];
   assign op_illegal  = dec_q.cls[0];
   assign src_imm     = dec_q.src_imm;
   assign src_ram     = dec_q.src_ram;
   assign if_zero     = dec_q.ifs[3];
   assign if_not_zero = dec_q.ifs[2];
   assign if_else     = dec_q.ifs[1];
   assign if_not_else = dec_q.ifs[0];

   // Next-state and held-field update; flush abandons whatever is in flight.
   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  dec_d   = new_dec;
                  state_d = new_fetch ? FETCH : FULL;
               end
            end
            FETCH: begin
               if (data_valid) begin
                  dec_d.rhs = place_data(data, dec_q.hi);
                  state_d   = FULL;
               end
            end
            FULL: begin
               if (out_ready) begin
                  if (accept) begin
                     dec_d   = new_dec;
                     state_d = new_fetch ? FETCH : FULL;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and decoded-field registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dec_q   <= '0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected results from a
// behavioural model, monitors pop and compare on every output transfer.
module tb_decode_stage;

   typedef struct packed {
      logic [7:0]  cls;
      logic [5:0]  fl;
      logic [23:0] rhs;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 16-bit instance signals
   logic        rst, flush, in_valid, in_ready, data_req, data_valid, out_valid, out_ready;
   logic [15:0] inst, rhs16;
   logic [7:0]  data;
   logic [7:0]  cls16;
   logic [5:0]  fl16;

   // 24-bit instance signals
   logic        flush24, in_valid24, in_ready24, data_req24, data_valid24, out_valid24, out_ready24;
   logic [23:0] inst24, rhs24;
   logic [7:0]  data24;
   logic [7:0]  cls24;
   logic [5:0]  fl24;

   exp_t        q16[$];
   exp_t        q24[$];
   logic [7:0]  dq[$];

   logic        ready_rand = 1'b0;
   logic        man_ready  = 1'b1;
   logic        resp_auto  = 1'b0;
   logic        man_dv     = 1'b0;
   logic [7:0]  man_d      = 8'h00;

   decode_stage #(.WIDTH(16), .DATA_WIDTH(8)) dut16 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .data_req(data_req), .data_valid(data_valid), .data(data),
      .out_valid(out_valid), .out_ready(out_ready), .rhs(rhs16),
      .op_nop(cls16[7]), .op_out_lo(cls16[6]), .op_load(cls16[5]), .op_add(cls16[4]),
      .op_store(cls16[3]), .op_branch(cls16[2]), .op_if(cls16[1]), .op_illegal(cls16[0]),
      .src_imm(fl16[5]), .src_ram(fl16[4]), .if_zero(fl16[3]), .if_not_zero(fl16[2]),
      .if_else(fl16[1]), .if_not_else(fl16[0])
   );

   decode_stage #(.WIDTH(24), .DATA_WIDTH(8)) dut24 (
      .clk(clk), .rst(rst), .flush(flush24), .in_valid(in_valid24), .in_ready(in_ready24),
      .inst(inst24), .data_req(data_req24), .data_valid(data_valid24), .data(data24),
      .out_valid(out_valid24), .out_ready(out_ready24), .rhs(rhs24),
      .op_nop(cls24[7]), .op_out_lo(cls24[6]), .op_load(cls24[5]), .op_add(cls24[4]),
      .op_store(cls24[3]), .op_branch(cls24[2]), .op_if(cls24[1]), .op_illegal(cls24[0]),
      .src_imm(fl24[5]), .src_ram(fl24[4]), .if_zero(fl24[3]), .if_not_zero(fl24[2]),
      .if_else(fl24[1]), .if_not_else(fl24[0])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: instruction classes and operand rules in plain arithmetic.
   function automatic exp_t model(input logic [15:0] i, input logic [7:0] d, input int w);
      exp_t   e;
      int     op5, hi8, m, lo, lo11;
      longint val, mask;
      e    = '0;
      val  = 0;
      op5  = int'(i[15:11]);
      hi8  = int'(i[15:8]);
      m    = int'(i[10:8]);
      lo   = int'(i[7:0]);
      lo11 = int'(i[10:0]);
      mask = (longint'(1) << w) - 1;
      if (hi8 == 0) e.cls = 8'b1000_0000;
      else if (hi8 == 8) e.cls = 8'b0100_0000;
      else if (op5 >= 16 && op5 <= 18) begin
         e.cls = 8'b0010_0000 >> (op5 - 16);
         if (m >= 4) begin
            e.fl = 6'b010000;
            val  = lo;
         end else begin
            e.fl = 6'b100000;
            case (m)
               0: val = lo;
               1: val = lo * 256;
               2: val = int'(d);
               default: val = int'(d) * 256;
            endcase
         end
      end else if (op5 == 24) begin
         e.cls = 8'b0000_0100;
         val   = (lo11 >= 1024) ? lo11 - 2048 : lo11;
      end else if (op5 == 30 && (lo11 == 0 || lo11 == 1 || lo11 == 16 || lo11 == 17)) begin
         e.cls = 8'b0000_0010;
         case (lo11)
            0:  e.fl = 6'b001000;
            1:  e.fl = 6'b000100;
            16: e.fl = 6'b000010;
            default: e.fl = 6'b000001;
         endcase
      end else begin
         e.cls = 8'b0000_0001;
      end
      e.rhs = 24'(val & mask);
      return e;
   endfunction

   function automatic logic model_fetch(input logic [15:0] i);
      return (i[15:11] >= 5'd16 && i[15:11] <= 5'd18) && (i[10:8] == 3'd2 || i[10:8] == 3'd3);
   endfunction

   function automatic logic [15:0] rand_inst();
      logic [1:0]  t;
      logic [15:0] r;
      t = 2'($urandom);
      case ($urandom % 8)
         0: r = {8'h00, 8'($urandom)};
         1: r = {8'h08, 8'($urandom)};
         2, 3: r = {5'(16 + $urandom % 3), 3'($urandom), 8'($urandom)};
         4: r = {5'b11000, 11'($urandom)};
         5: r = {5'b11110, 6'd0, t[1], 3'd0, t[0]};
         default: r = 16'($urandom);
      endcase
      return r;
   endfunction

   task automatic send(input logic [15:0] i, input logic [7:0] d, output int waits);
      logic acc;
      waits    = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      inst     = i;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) begin
            waits++;
            if (waits > 200) begin
               check("accept_timeout16", 64'(0), 64'(1));
               break;
            end
         end
      end
      in_valid = 1'b0;
      if (acc) begin
         q16.push_back(model(i, d, 16));
         if (model_fetch(i)) dq.push_back(d);
      end
   endtask

   task automatic send24(input logic [15:0] i, input logic [7:0] d);
      logic acc;
      int   waits;
      waits      = 0;
      acc        = 1'b0;
      in_valid24 = 1'b1;
      inst24     = {8'($urandom), i};
      while (!acc) begin
         @(negedge clk);
         acc = in_ready24;
         @(posedge clk);
         #1;
         if (!acc) begin
            waits++;
            if (waits > 200) begin
               check("accept_timeout24", 64'(0), 64'(1));
               break;
            end
         end
      end
      in_valid24 = 1'b0;
      if (acc) q24.push_back(model(i, d, 24));
   endtask

   // Monitor for the 16-bit instance: transfers, one-hot class, hold stability.
   initial begin
      logic       held;
      logic [37:0] snap, cur;
      exp_t       e;
      held = 1'b0;
      snap = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            cur = {cls16, fl16, 8'h00, rhs16};
            if (held && out_valid) check("hold_stable16", 64'(cur), 64'(snap));
            if (out_valid) check("onehot16", 64'($onehot(cls16)), 64'(1));
            if (out_valid && out_ready) begin
               if (q16.size() == 0) begin
                  check("unexpected_out16", 64'(out_valid), 64'(0));
               end else begin
                  e = q16.pop_front();
                  check("xfer16", 64'(cur), 64'(e));
               end
            end
            held = out_valid && !out_ready;
            snap = cur;
         end
      end
   end

   // Monitor for the 24-bit instance.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid24 && out_ready24) begin
            if (q24.size() == 0) begin
               check("unexpected_out24", 64'(out_valid24), 64'(0));
            end else begin
               e = q24.pop_front();
               check("xfer24", 64'({cls24, fl24, rhs24}), 64'(e));
            end
         end
      end
   end

   // Data-port responder: random latency in auto mode, manual drive otherwise.
   initial begin
      data_valid = 1'b0;
      data       = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (!resp_auto) begin
            data_valid = man_dv;
            data       = man_d;
         end else if (data_req) begin
            if (dq.size() > 0 && ($urandom % 2) == 0) begin
               data_valid = 1'b1;
               data       = dq.pop_front();
            end else begin
               data_valid = 1'b0;
               data       = 8'($urandom);
            end
         end else begin
            data_valid = ($urandom % 3) == 0;
            data       = 8'($urandom);
         end
      end
   end

   // Execute-side ready driver.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = ready_rand ? (($urandom % 4) != 0) : man_ready;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; inst = 16'h8012;
      flush24 = 1'b0; in_valid24 = 1'b1; inst24 = 24'h008012; data_valid24 = 1'b0;
      data24 = 8'h00; out_ready24 = 1'b1;

      // Reset held two cycles with in_valid high
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs16", 64'({out_valid, data_req, cls16, fl16, rhs16}), 64'(0));
      check("reset_outs24", 64'({out_valid24, data_req24, cls24, fl24, rhs24}), 64'(0));
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid24 = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready16", 64'(in_ready), 64'(1));
      check("reset_in_ready24", 64'(in_ready24), 64'(1));
      check("reset_nothing_accepted", 64'({out_valid, data_req}), 64'(0));
      @(posedge clk); #1;

      // Back-to-back stream
      send(16'h8012, 8'h00, w); check("stream_wait0", 64'(w), 64'(0));
      send(16'h8112, 8'h00, w); check("stream_wait1", 64'(w), 64'(0));
      send(16'hC7FF, 8'h00, w); check("stream_wait2", 64'(w), 64'(0));
      send(16'hF011, 8'h00, w); check("stream_wait3", 64'(w), 64'(0));
      send(16'h1234, 8'h00, w); check("stream_wait4", 64'(w), 64'(0));
      repeat (3) @(posedge clk); #1;

      // Data fetch, data_valid three cycles after data_req
      send(16'h8B00, 8'hA5, w);
      @(negedge clk);
      check("fetch_data_req", 64'({data_req, out_valid}), 64'(2'b10));
      repeat (3) @(posedge clk); #1;
      man_dv = 1'b1; man_d = 8'hA5;
      @(negedge clk);
      check("fetch_not_yet", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      man_dv = 1'b0; man_d = 8'h3C;
      @(negedge clk);
      check("fetch_out_valid", 64'({data_req, out_valid}), 64'(2'b01));
      @(posedge clk); #1;

      // Data fetch, data_valid in the first data_req cycle
      send(16'h8A33, 8'h5C, w);
      man_dv = 1'b1; man_d = 8'h5C;
      @(posedge clk); #1;
      man_dv = 1'b0; man_d = 8'hEE;
      @(negedge clk);
      check("fetch_fast_out_valid", 64'(out_valid), 64'(1));
      repeat (2) @(posedge clk); #1;

      // Backpressure
      man_ready = 1'b0;
      send(16'h8012, 8'h00, w);
      in_valid = 1'b1; inst = 16'h8155;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_in_ready_low", 64'({in_ready, out_valid}), 64'(2'b01));
         @(posedge clk); #1;
      end
      man_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_high", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      q16.push_back(model(16'h8155, 8'h00, 16));
      in_valid = 1'b0;
      repeat (3) @(posedge clk); #1;

      // Flush during fetch
      send(16'h9200, 8'h00, w);
      void'(q16.pop_back());
      dq.delete();
      @(negedge clk);
      check("flush_pre_data_req", 64'(data_req), 64'(1));
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; inst = 16'h0800;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      man_dv = 1'b1; man_d = 8'h77;
      @(negedge clk);
      check("flush_dropped", 64'({data_req, out_valid}), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("flush_late_data", 64'({data_req, out_valid}), 64'(0));
      @(posedge clk); #1;
      man_dv = 1'b0;
      repeat (2) @(posedge clk); #1;

      // 24-bit instance: sign extension, flush, high-lane fetch
      send24(16'hC400, 8'h00);
      repeat (2) @(posedge clk); #1;
      send24(16'h9200, 8'h00);
      void'(q24.pop_back());
      @(negedge clk);
      check("w24_data_req", 64'(data_req24), 64'(1));
      @(posedge clk); #1;
      flush24 = 1'b1;
      @(posedge clk); #1;
      flush24 = 1'b0; data_valid24 = 1'b1; data24 = 8'h66;
      @(negedge clk);
      check("w24_flush_dropped", 64'({data_req24, out_valid24}), 64'(0));
      @(posedge clk); #1;
      data_valid24 = 1'b0;
      @(negedge clk);
      check("w24_late_data", 64'(out_valid24), 64'(0));
      @(posedge clk); #1;
      send24(16'h8B00, 8'hA5);
      data_valid24 = 1'b1; data24 = 8'hA5;
      @(posedge clk); #1;
      data_valid24 = 1'b0;
      repeat (3) @(posedge clk); #1;

      // Randomized traffic against the model
      dq.delete();
      resp_auto  = 1'b1;
      ready_rand = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if (($urandom % 3) == 0) begin
            @(posedge clk); #1;
         end
         send(rand_inst(), 8'($urandom), w);
      end
      ready_rand = 1'b0;
      man_ready  = 1'b1;
      for (int c = 0; c < 200 && q16.size() > 0; c++) begin
         @(posedge clk); #1;
      end
      repeat (2) @(posedge clk); #1;
      check("drain16", 64'(q16.size()), 64'(0));
      check("drain24", 64'(q24.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction decode stage that replaces the purely combinational decoder in the CPU datapath. It accepts one instruction word per cycle from fetch and fetches an operand from the data port when the source mode requires it. It presents registered decode flags and a WIDTH-bit right-hand operand to execute over a valid/ready interface. It is generalised in word width and data width, and adds illegal-opcode detection, a flush input and stall handling.

## Interface
- WIDTH, 16: instruction/operand word width; must be ≥ 16.
- DATA_WIDTH, 8: data-port width; must be ≤ WIDTH-8.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous drop of any held or pending instruction.
- in_valid  in  1  fetch presents inst.
- in_ready  out  1  stage will accept inst this cycle.
- inst  in  WIDTH  instruction word; only bits [15:0] are decoded, upper bits are ignored.
- data_req  out  1  operand fetch request.
- data_valid  in  1  data holds the requested operand.
- data  in  DATA_WIDTH  operand value.
- out_valid  out  1  decoded result held on outputs.
- out_ready  in  1  execute consumes the result.
- rhs  out  WIDTH  right-hand operand.
- op_nop, op_out_lo, op_load, op_add, op_store, op_branch, op_if, op_illegal  out  1 each  one-hot class; exactly one is high while out_valid.
- src_imm, src_ram  out  1 each  operand source.
- if_zero, if_not_zero, if_else, if_not_else  out  1 each  condition select.

## Operation
- Class decode on i = inst[15:0]:
  - nop: i[15:8] = 0x00.
  - out_lo: i[15:8] = 0x08.
  - load: i[15:11] = 10000.
  - add: 10001.
  - store: 10010.
  - branch: 11000.
  - if: 11110 with i[10:0] ∈ {0x000, 0x001, 0x010, 0x011}. These map to if_zero, if_not_zero, if_else and if_not_else respectively.
  - Everything else is op_illegal, with rhs = 0 and all src/if flags 0.
- Source mode m = i[10:8], for load/add/store only:
  - 000: imm lo; rhs = zext(i[7:0]); src_imm = 1.
  - 001: imm hi; rhs = zext(i[7:0]) << 8; src_imm = 1.
  - 010: data lo; rhs = zext(data); src_imm = 1; requires fetch.
  - 011: data hi; rhs = zext(data) << 8, truncated to WIDTH; src_imm = 1; requires fetch.
  - 1xx: ram; rhs = zext(i[7:0]); src_ram = 1.
- Branch: rhs = sign-extend i[10:0] to WIDTH; src flags 0.
- nop, out_lo and if: rhs = 0.
- FSM states: IDLE, FETCH, FULL.
  - IDLE: in_ready = 1. On in_valid, decode and register the result. Next state is FETCH if the instruction requires a fetch, otherwise FULL.
  - FETCH: data_req = 1; in_ready = 0. On data_valid, capture data into rhs per m; next state is FULL.
  - FULL: out_valid = 1; in_ready = out_ready.
    - out_ready && in_valid: load the new instruction, then go to FETCH or FULL. This gives back-to-back throughput.
    - out_ready && !in_valid: go to IDLE.
    - !out_ready: hold every output stable.
- data_valid outside FETCH is ignored.
- Priority: rst > flush > handshakes.
  - flush forces IDLE and clears out_valid and data_req on the next edge.
  - in_ready is 0 in any cycle where flush = 1, so no instruction is accepted.

## Timing
- Reset value of every output is 0, except in_ready = 1 after reset (IDLE). State is IDLE.
- Latency, non-fetch instruction: accepted at edge N; out_valid and fields valid after edge N.
- Latency, fetch instruction: accepted at edge N; data_req high after N.
  - data_valid may arrive in the same cycle data_req first rises, or any later cycle.
  - If data_valid is sampled at edge M, out_valid is high after M.
- data_req is a registered state decode; it is never combinational from inputs.
- out_valid, once high, stays high with outputs unchanged until an edge where out_ready = 1, or a flush or rst.
- rst or flush during FETCH abandons the fetch. data_req drops after that edge; a late data_valid is ignored.
- Sustained throughput is one instruction per cycle for non-fetch instructions. A fetch instruction costs at least one extra cycle.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 → all outputs 0, in_ready = 1, nothing accepted.
- Stream with out_ready = 1 of 0x8012, 0x8112, 0xC7FF, 0xF011, 0x1234, each accepted in consecutive cycles:
  - 0x8012 → op_load, rhs 0x0012, src_imm.
  - 0x8112 → rhs 0x1200.
  - 0xC7FF → op_branch, rhs 0xFFFF.
  - 0xF011 → if_not_else.
  - 0x1234 → op_illegal, rhs 0.
- Data fetch: 0x8B00; data_valid with data = 0xA5 three cycles after data_req → op_add, rhs 0xA500, out_valid one cycle after data_valid. A second run with data_valid in the first data_req cycle gives out_valid one cycle after acceptance of that data.
- Backpressure: out_ready = 0 for 4 cycles with in_valid = 1 → in_ready = 0 and outputs stable; raising out_ready transfers the old result and loads the next instruction in the same edge.
- Flush: issue 0x9200 and assert flush while data_req = 1 → IDLE, out_valid never rises, and a later data_valid is ignored. Repeat with WIDTH = 24: 0xC400 gives rhs 0xFFFC00.
